npu_mem_responder: RTL and testbench

Memory-side responder for the NPU core's single-outstanding memory request interface. It answers level-held `mem_re`/`mem_we` requests with a word-addressed scratchpad, configurable read and write latency, and optional stall injection. Every request ends in exactly one `mem_valid` pulse, including illegal ones, so the initiator never hangs. It sits between `npu_core` and on-chip storage and replaces the testbench memory model in integration.

---
 rtl/npu_mem_pkg.sv | 16 +
 rtl/npu_sram_array.sv | 27 ++
 rtl/npu_mem_responder.sv | 137 +++++++++++++
 tb/tb_npu_mem_responder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/npu_mem_pkg.sv
// Shared types and constants for the NPU memory responder and its initiators.
package npu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_resp_state_t;

    localparam logic [7:0] ERR_COUNT_MAX = 8'hFF;

    // Opcodes of the core's memory instructions, shared with benches.
    localparam logic [7:0] OP_LOAD  = 8'h10;
    localparam logic [7:0] OP_STORE = 8'h11;

endpackage

// File: rtl/npu_sram_array.sv
// Word-wide scratchpad: one synchronous write port, one synchronous read port, no reset.
module npu_sram_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [IDX_W-1:0]      raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/npu_mem_responder.sv
// Single-outstanding memory responder for npu_core: scratchpad with configurable
// read/write latency, stall injection and an illegal-request counter.
module npu_mem_responder
    import npu_mem_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int DEPTH         = 256,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_we,
    input  logic                  mem_re,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_valid,
    input  logic                  stall,
    output logic                  busy,
    output logic [7:0]            err_count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);
    localparam logic [3:0] RD_LAT = 4'(READ_LATENCY);
    localparam logic [3:0] WR_LAT = 4'(WRITE_LATENCY);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == ERR_COUNT_MAX) ? v : v + 8'd1;
    endfunction

    mem_resp_state_t state, state_nxt;

    logic [3:0]       cnt_q;
    logic [IDX_W-1:0] addr_q;
    logic             is_rd_q;
    logic             is_err_q;
    logic             rd_zero_q;

    logic             accept;
    logic             req_err;
    logic             req_wr;
    logic [3:0]       lat_sel;
    logic             resp_load;
    logic             cur_rd;
    logic             cur_err;
    logic             sram_re;
    logic [IDX_W-1:0] sram_raddr;
    logic [DATA_WIDTH-1:0] sram_rdata;

    assign accept  = (state == IDLE) && (mem_re || mem_we);
    assign req_err = (mem_re && mem_we) || (mem_addr >= DEPTH_A);
    assign req_wr  = mem_we && !req_err;
    assign lat_sel = req_wr ? WR_LAT : RD_LAT;

    // Read data is fetched on the edge that enters RESP; with LAT==1 that is the
    // acceptance edge itself, so the live request is used instead of the captured one.
    assign resp_load  = (state_nxt == RESP) && (state != RESP);
    assign cur_rd     = (state == IDLE) ? !req_wr  : is_rd_q;
    assign cur_err    = (state == IDLE) ? req_err  : is_err_q;
    assign sram_re    = resp_load && cur_rd && !cur_err;
    assign sram_raddr = (state == IDLE) ? mem_addr[IDX_W-1:0] : addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The counter holds the cycles left until RESP, so leaving WAIT happens on
    // the unstalled edge that brings it to zero.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = (lat_sel == 4'd1) ? RESP : WAIT;
            WAIT: if (!stall && (cnt_q == 4'd1)) state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_valid = (state == RESP);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= 4'd0;
            is_rd_q   <= 1'b0;
            is_err_q  <= 1'b0;
            rd_zero_q <= 1'b1;
            err_count <= 8'd0;
        end else begin
            if (accept) begin
                cnt_q    <= lat_sel - 4'd1;
                is_rd_q  <= !req_wr;
                is_err_q <= req_err;
                if (req_err) begin
                    err_count <= sat_inc(err_count);
                end
            end else if ((state == WAIT) && !stall) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (resp_load && cur_rd) begin
                rd_zero_q <= cur_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q <= mem_addr[IDX_W-1:0];
        end
    end

    npu_sram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_sram (
        .clk   (clk),
        .we    (accept && req_wr),
        .waddr (mem_addr[IDX_W-1:0]),
        .wdata (mem_wdata),
        .re    (sram_re),
        .raddr (sram_raddr),
        .rdata (sram_rdata)
    );

    // Reset and error responses present zero without touching the unreset array.
    assign mem_rdata = rd_zero_q ? '0 : sram_rdata;

endmodule

// File: tb/tb_npu_mem_responder.sv
// Directed bench for npu_mem_responder: latency, stall, errors, hold, reset and a load/store flow.
module tb_npu_mem_responder;
    import npu_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic        stall;
    logic        busy;
    logic [7:0]  err_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    npu_mem_responder #(
        .DATA_WIDTH    (32),
        .ADDR_WIDTH    (32),
        .DEPTH         (256),
        .READ_LATENCY  (2),
        .WRITE_LATENCY (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid),
        .stall     (stall),
        .busy      (busy),
        .err_count (err_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drives one request at a negedge, holds it until mem_valid, then drops it.
    // stall is high for cycles st_start .. st_start+st_len-1 (cycle 0 = request cycle).
    // bad counts busy low before the response or any activity the cycle after it.
    task automatic do_req(input logic re, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int st_start, input int st_len,
                          output int lat, output logic [31:0] rdata, output int bad);
        int  k;
        bit  done;
        @(negedge clk);
        mem_re    = re;
        mem_we    = we;
        mem_addr  = addr;
        mem_wdata = wdata;
        stall     = (st_len > 0) && (st_start == 0);
        k = 0; done = 0; bad = 0; lat = -1; rdata = '0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
            if (!busy) bad++;
            if (mem_valid) begin
                lat   = k;
                rdata = mem_rdata;
                done  = 1;
            end else begin
                stall = (k >= st_start) && (k < st_start + st_len);
            end
        end
        mem_re = 1'b0;
        mem_we = 1'b0;
        stall  = 1'b0;
        @(negedge clk);
        if (mem_valid || busy) bad++;
    endtask

    task automatic host_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                           output int lat, output logic [31:0] rdata, output int bad);
        do_req(op == OP_LOAD, op == OP_STORE, addr, data, 0, 0, lat, rdata, bad);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          bad;
        int          pulses;
        logic [31:0] rd;

        rst_n = 1'b0; mem_addr = '0; mem_wdata = '0; mem_we = 1'b0; mem_re = 1'b0; stall = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_valid", 32'(mem_valid), 32'd0);
        check_eq("rst_rdata", mem_rdata, 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_err", 32'(err_count), 32'd0);
        rst_n = 1'b1;

        do_req(1'b0, 1'b1, 32'h05, 32'hCAFEF00D, 0, 0, lat, rd, bad);
        check_eq("wr_lat", lat, 32'd1);
        check_eq("wr_busy", bad, 32'd0);
        check_eq("wr_rdata_kept", rd, 32'd0);

        do_req(1'b1, 1'b0, 32'h05, 32'h0, 0, 0, lat, rd, bad);
        check_eq("rd_lat", lat, 32'd2);
        check_eq("rd_data", rd, 32'hCAFEF00D);
        check_eq("rd_busy", bad, 32'd0);

        do_req(1'b1, 1'b0, 32'h05, 32'h0, 1, 3, lat, rd, bad);
        check_eq("stall_lat", lat, 32'd5);
        check_eq("stall_data", rd, 32'hCAFEF00D);
        check_eq("stall_busy_pulse", bad, 32'd0);

        do_req(1'b0, 1'b1, 32'h09, 32'h55AA55AA, 0, 3, lat, rd, bad);
        check_eq("stall_lat1", lat, 32'd1);

        do_req(1'b1, 1'b0, 32'h100, 32'h0, 0, 0, lat, rd, bad);
        check_eq("oor_lat", lat, 32'd2);
        check_eq("oor_data", rd, 32'd0);
        check_eq("oor_err", 32'(err_count), 32'd1);

        do_req(1'b1, 1'b1, 32'h05, 32'hDEADBEEF, 0, 0, lat, rd, bad);
        check_eq("dbl_lat", lat, 32'd2);
        check_eq("dbl_data", rd, 32'd0);
        check_eq("dbl_err", 32'(err_count), 32'd2);

        do_req(1'b0, 1'b1, 32'h1000_0005, 32'h12345678, 0, 0, lat, rd, bad);
        check_eq("oor_wr_lat", lat, 32'd2);
        check_eq("oor_wr_err", 32'(err_count), 32'd3);

        do_req(1'b1, 1'b0, 32'h05, 32'h0, 0, 0, lat, rd, bad);
        check_eq("array_unchanged", rd, 32'hCAFEF00D);
        do_req(1'b1, 1'b0, 32'h09, 32'h0, 0, 0, lat, rd, bad);
        check_eq("rd_addr9", rd, 32'h55AA55AA);

        // Hold mem_re through the RESP cycle, drop it just after the edge leaving RESP.
        @(negedge clk);
        mem_re = 1'b1; mem_addr = 32'h05;
        pulses = 0;
        repeat (2) begin
            @(negedge clk);
            if (mem_valid) pulses++;
        end
        check_eq("hold_valid_at_lat", 32'(mem_valid), 32'd1);
        @(posedge clk);
        #1 mem_re = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (mem_valid || busy) pulses++;
        end
        check_eq("hold_single_pulse", pulses, 32'd1);

        // Back-to-back: second request held straight after RESP, period LAT+1.
        @(negedge clk);
        mem_re = 1'b1; mem_addr = 32'h05;
        repeat (2) @(negedge clk);
        check_eq("b2b_first_valid", 32'(mem_valid), 32'd1);
        check_eq("b2b_first_data", mem_rdata, 32'hCAFEF00D);
        mem_addr = 32'h09;
        @(negedge clk);
        check_eq("b2b_gap", 32'(mem_valid), 32'd0);
        repeat (2) @(negedge clk);
        check_eq("b2b_second_valid", 32'(mem_valid), 32'd1);
        check_eq("b2b_second_data", mem_rdata, 32'h55AA55AA);
        mem_re = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 260; i++) begin
            do_req(1'b1, 1'b0, 32'h200, 32'h0, 0, 0, lat, rd, bad);
        end
        check_eq("err_saturate", 32'(err_count), 32'd255);

        // Reset while a stalled read sits in WAIT.
        @(negedge clk);
        mem_re = 1'b1; mem_addr = 32'h05; stall = 1'b1;
        @(negedge clk);
        check_eq("wait_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rstw_valid", 32'(mem_valid), 32'd0);
        check_eq("rstw_busy", 32'(busy), 32'd0);
        check_eq("rstw_err", 32'(err_count), 32'd0);
        mem_re = 1'b0; stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        do_req(1'b0, 1'b1, 32'h07, 32'h11112222, 0, 0, lat, rd, bad);
        // Reset in the RESP cycle must drop mem_valid at once.
        @(negedge clk);
        mem_re = 1'b1; mem_addr = 32'h07;
        repeat (2) @(negedge clk);
        check_eq("resp_valid_before_rst", 32'(mem_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rstr_valid", 32'(mem_valid), 32'd0);
        check_eq("rstr_rdata", mem_rdata, 32'd0);
        mem_re = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        do_req(1'b1, 1'b0, 32'h07, 32'h0, 0, 0, lat, rd, bad);
        check_eq("post_rst_rd7", rd, 32'h11112222);
        do_req(1'b1, 1'b0, 32'h05, 32'h0, 0, 0, lat, rd, bad);
        check_eq("post_rst_rd5", rd, 32'hCAFEF00D);

        host_op(OP_STORE, 32'h20, 32'h0BADC0DE, lat, rd, bad);
        check_eq("store_lat", lat, 32'd1);
        host_op(OP_LOAD, 32'h20, 32'h0, lat, rd, bad);
        check_eq("load_data", rd, 32'h0BADC0DE);
        check_eq("load_bad", bad, 32'd0);
        check_eq("host_err", 32'(err_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
